pwm_multi_gen: RTL
==================

// Module: pwm_multi_gen
// PURPOSE
//  Multi-channel PWM generator for motor ESC / servo drive in the drone SoC.
//  One shared prescaler and period counter; per-channel duty registers are
//  double-buffered and committed only at the period boundary, so outputs are
//  glitch-free. Duty/period are loaded by a controller via a valid/ready port.
// PARAMETERS
//  NUM_CH          4    number of PWM output channels (>=1)
//  CNT_W           16   width of period counter, period and duty values
//  PRESCALE        532  clk cycles per counter tick (>=1)
//  DEFAULT_PERIOD  100  period in ticks after reset (1..2^CNT_W-1)
//  ACTIVE_HIGH     1    1: active level is 1; 0: outputs inverted
//  FAILSAFE_PERIODS 50  periods without a duty write before failsafe (macro only)
//  localparam CH_W = max(1, $clog2(NUM_CH))
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       asynchronous reset, active low
//  enable        in   1       run PWM; low = counters held, outputs inactive
//  period_in     in   CNT_W   new period in ticks
//  period_wr     in   1       one-clk strobe: load period_in into shadow period
//  duty_in       in   CNT_W   new duty in ticks
//  duty_ch       in   CH_W    channel index for duty_in
//  duty_valid    in   1       duty write request
//  duty_ready    out  1       duty write accepted when valid && ready
//  pwm_out       out  NUM_CH  PWM outputs, registered
//  period_start  out  1       one-clk pulse on each period wrap/commit
//  failsafe      out  1       failsafe active (0 when macro absent)
// BEHAVIOUR
//  Reset (async assert, sync release): prescaler=0, cnt=0, shadow/active duty=0,
//   shadow/active period=DEFAULT_PERIOD, pwm_out=inactive level (all 0 if
//   ACTIVE_HIGH else all 1), duty_ready=1, period_start=0, failsafe=0.
//  Tick: prescaler counts 0..PRESCALE-1 while enable; tick when at PRESCALE-1.
//  Period: on tick, cnt increments; at cnt==period_act-1 it wraps to 0 = commit.
//  Commit cycle: duty_act[i]<=duty_sh[i], period_act<=period_sh, period_start=1
//   (registered, same clk as cnt wrap), duty_ready=0 for that clk only.
//  Duty handshake: accept when duty_valid&&duty_ready -> duty_sh[duty_ch]<=duty_in.
//   duty_ch>=NUM_CH: accepted, discarded. Holding valid across ready=0 is legal.
//  period_wr: period_sh<=period_in; value 0 clamped to 1. period_wr coincident
//   with commit: commit uses old shadow, new value applies at following commit.
//  Output: pwm_out[i] = active when cnt < duty_act[i]; one clk latency from cnt.
//   duty 0 -> always inactive; duty >= period_act -> always active (100%).
//  New values take effect from the first full period after the next commit.
//  enable low: prescaler, cnt forced 0; pwm_out inactive; shadow writes still
//   accepted. enable rising: immediate commit (period_start pulse), new period.
//  Reset mid-period: outputs go inactive asynchronously; period restarts at 0.
//  Arithmetic: unsigned CNT_W compares; cnt never exceeds period_act-1.
// CONFIGURATION
//  PWM_FAILSAFE_EN defined: CNT_W-wide counter of commits since last accepted
//   duty write (any channel). Reaching FAILSAFE_PERIODS sets failsafe=1 and
//   clears all duty_sh to 0 so the next commit drives outputs inactive; writes
//   during failsafe are accepted, clear failsafe and the counter.
//  PWM_FAILSAFE_EN undefined: no counter, failsafe tied 0, duties held forever.
// TESTING  (NUM_CH=2, PRESCALE=1, DEFAULT_PERIOD=10, ACTIVE_HIGH=1)
//  1 Release rst_n, enable=1 -> period_start every 10 clk, pwm_out=2'b00;
//    rst_n low mid-period -> pwm_out=0 at once, restart cnt=0 after release.
//  2 Write ch0=3, ch1=7 -> after next period_start ch0 high 3/10 clk,
//    ch1 high 7/10 clk; no glitch in the period the write occurred.
//  3 ch0=0 -> constant 0; ch1=10 and then 12 -> constant 1.
//  4 period_wr 4 mid-period -> current 10-clk period completes, then
//    period_start every 4 clk; period_wr 0 -> period 1.
//  5 duty_valid held over commit clk -> duty_ready=0 that clk, accepted next
//    clk, applied at following commit; duty_ch=3 -> accepted, no output change.
//  6 PWM_FAILSAFE_EN, FAILSAFE_PERIODS=3, ch0=5, no writes -> failsafe=1 after
//    3rd commit, ch0 low from 4th period; write ch0=5 -> failsafe=0 at once.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaler and period counter, double-buffered duty/period.
// Optional failsafe timeout is compiled in when PWM_FAILSAFE_EN is defined.
module pwm_multi_gen #(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 16,
   parameter int PRESCALE       = 532,
   parameter int DEFAULT_PERIOD = 100,
   parameter int ACTIVE_HIGH    = 1,
`ifdef PWM_FAILSAFE_EN
   parameter int FAILSAFE_PERIODS = 50,
`endif
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [CNT_W-1:0]  period_in,
   input  logic              period_wr,
   input  logic [CNT_W-1:0]  duty_in,
   input  logic [CH_W-1:0]   duty_ch,
   input  logic              duty_valid,
   output logic              duty_ready,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_start,
   output logic              failsafe
);

   localparam int               PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic             INACT      = (ACTIVE_HIGH == 0);
   localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEFAULT_PERIOD);

   function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
      return (p == '0) ? CNT_W'(1) : p;
   endfunction

   function automatic logic drive_level(input logic active);
      return active ^ INACT;
   endfunction

   logic [PS_W-1:0]   prescale_q, prescale_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  period_sh_q, period_sh_d;
   logic [CNT_W-1:0]  period_act_q, period_act_d;
   logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
   logic [CNT_W-1:0]  duty_sh_d  [NUM_CH];
   logic [CNT_W-1:0]  duty_act_q [NUM_CH];
   logic [CNT_W-1:0]  duty_act_d [NUM_CH];
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              en_q, en_d;
   logic              period_start_q, period_start_d;
   logic              duty_ready_q, duty_ready_d;

   logic tick;
   logic wrap;
   logic commit;
   logic accept;
   logic fs_trip;

   // A commit happens on a natural wrap or immediately when enable rises.
   always_comb begin
      tick   = enable && (prescale_q == PS_LAST);
      wrap   = tick && (cnt_q == (period_act_q - CNT_W'(1)));
      commit = enable && (!en_q || wrap);
      accept = duty_valid && duty_ready_q;
   end

   always_comb begin
      en_d           = enable;
      period_start_d = commit;
      duty_ready_d   = !commit;

      if (!enable || tick) begin
         prescale_d = '0;
      end else begin
         prescale_d = prescale_q + PS_W'(1);
      end

      if (!enable || commit) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end

      period_sh_d  = period_wr ? clamp_period(period_in) : period_sh_q;
      period_act_d = commit ? period_sh_q : period_act_q;

      for (int i = 0; i < NUM_CH; i++) begin
         duty_act_d[i] = commit ? duty_sh_q[i] : duty_act_q[i];
         duty_sh_d[i]  = duty_sh_q[i];
         // Out-of-range channel indices match no entry and are silently dropped.
         if (accept && (duty_ch == CH_W'(i))) begin
            duty_sh_d[i] = duty_in;
         end
         if (fs_trip) begin
            duty_sh_d[i] = '0;
         end
         pwm_d[i] = enable ? drive_level(cnt_q < duty_act_q[i]) : INACT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q     <= '0;
         cnt_q          <= '0;
         period_sh_q    <= PERIOD_RST;
         period_act_q   <= PERIOD_RST;
         pwm_q          <= {NUM_CH{INACT}};
         en_q           <= 1'b0;
         period_start_q <= 1'b0;
         duty_ready_q   <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_sh_q[i]  <= '0;
            duty_act_q[i] <= '0;
         end
      end else begin
         prescale_q     <= prescale_d;
         cnt_q          <= cnt_d;
         period_sh_q    <= period_sh_d;
         period_act_q   <= period_act_d;
         pwm_q          <= pwm_d;
         en_q           <= en_d;
         period_start_q <= period_start_d;
         duty_ready_q   <= duty_ready_d;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_sh_q[i]  <= duty_sh_d[i];
            duty_act_q[i] <= duty_act_d[i];
         end
      end
   end

`ifdef PWM_FAILSAFE_EN
   localparam logic [CNT_W-1:0] FS_LIMIT = CNT_W'(FAILSAFE_PERIODS);

   logic [CNT_W-1:0] fs_cnt_q, fs_cnt_d;
   logic             failsafe_q, failsafe_d;

   // Counting stops once tripped; the next accepted write re-arms it.
   always_comb begin
      fs_cnt_d   = fs_cnt_q;
      failsafe_d = failsafe_q;
      fs_trip    = 1'b0;
      if (accept) begin
         fs_cnt_d   = '0;
         failsafe_d = 1'b0;
      end else if (commit && !failsafe_q) begin
         fs_cnt_d = fs_cnt_q + CNT_W'(1);
         if (fs_cnt_d >= FS_LIMIT) begin
            failsafe_d = 1'b1;
            fs_trip    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fs_cnt_q   <= '0;
         failsafe_q <= 1'b0;
      end else begin
         fs_cnt_q   <= fs_cnt_d;
         failsafe_q <= failsafe_d;
      end
   end

   assign failsafe = failsafe_q;
`else
   assign fs_trip  = 1'b0;
   assign failsafe = 1'b0;
`endif

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
   assign duty_ready   = duty_ready_q;

endmodule
